// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM states, burst
// limits and counter width.
package fifo_arb_pkg;

  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req_i scanning upward
// from ptr_i, wrapping at NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ptr_i < NUM_REQ, so one subtraction is enough to wrap.
      pos = 32'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// producers; bounded bursts, zero-latency forwarding, full-gated writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     wr_clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     wr_full,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         data_in,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic             gnt_valid, gnt_last;
  logic [WIDTH-1:0] gnt_data;
  logic             in_burst, xfer, burst_end;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] grant_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign xfer      = in_burst & gnt_valid & ~wr_full;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign grant_inc = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // A dropped valid ends the burst even while the FIFO is full.
  assign burst_end = in_burst &
                     (~gnt_valid | (xfer & (gnt_last | (cnt_inc == CNT_W'(MAX_BURST)))));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) cnt_d = cnt_inc;
        if (burst_end) begin
          rr_ptr_d = grant_inc;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (in_burst && !wr_full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_q == IDX_W'(i));
      end
    end
  end

  assign wr_en    = xfer;
  assign data_in  = in_burst ? gnt_data : '0;
  assign grant_id = grant_q;
  assign busy     = in_burst;

  a_no_overflow: assert property (@(posedge wr_clk) disable iff (!reset_n)
    !(wr_en && wr_full));
  a_ready_onehot: assert property (@(posedge wr_clk) disable iff (!reset_n)
    $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester word queues feed the
// DUT, a behavioural model predicts every output each cycle.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MB = 4;

  logic            wr_clk;
  logic            reset_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*W-1:0]  req_data;
  logic            wr_full, wr_en, busy;
  logic [W-1:0]    data_in;
  logic [IW-1:0]   grant_id;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .NUM_REQ   (N),
    .IDX_W     (IW),
    .MAX_BURST (MB)
  ) dut (
    .wr_clk    (wr_clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  int total = 0;
  int bad   = 0;

  // Pending words per requester: {last, data}
  logic [8:0]  pq [N][256];
  int unsigned hd [N];
  int unsigned tl [N];

  // Model state
  bit          m_burst;
  int          m_ptr, m_g, m_cnt;
  logic [N-1:0] xfer_v;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    pq[r][tl[r] % 256] = {l, d};
    tl[r]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (tl[i] != hd[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = pq[i][hd[i] % 256][7:0];
        req_last[i]        = pq[i][hd[i] % 256][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Mid-cycle: compare DUT outputs with the model's prediction.
  task automatic sample();
    logic [N-1:0] e_ready;
    logic         e_wen;
    logic [7:0]   e_data;
    #4;
    xfer_v = '0;
    if (!reset_n) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_data_in", data_in, 0);
    end else begin
      e_ready = (m_burst && !wr_full) ? N'(1 << m_g) : '0;
      e_wen   = m_burst && req_valid[m_g] && !wr_full;
      e_data  = req_data[m_g*W +: W];
      chk("wr_en", wr_en, e_wen);
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, m_burst);
      chk("grant_id", grant_id, m_g);
      if (m_burst) chk("data_in", data_in, e_data);
      if (e_wen) xfer_v = N'(1 << m_g);
    end
  endtask

  // Clock edge: advance model, consume transferred words, present next words.
  task automatic edge_step();
    @(posedge wr_clk);
    if (!reset_n) begin
      m_burst = 0; m_ptr = 0; m_g = 0; m_cnt = 0;
    end else if (!m_burst) begin
      for (int k = 0; k < N; k++) begin
        if (!m_burst && req_valid[(m_ptr + k) % N]) begin
          m_g     = (m_ptr + k) % N;
          m_cnt   = 0;
          m_burst = 1;
        end
      end
    end else if (!req_valid[m_g]) begin
      m_burst = 0;
      m_ptr   = (m_g + 1) % N;
    end else if (!wr_full) begin
      m_cnt++;
      if (req_last[m_g] || m_cnt == MB) begin
        m_burst = 0;
        m_ptr   = (m_g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) if (xfer_v[i]) hd[i]++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_full = 1'b0;
    clear_q();
    drive();
    repeat (2) begin
      sample();
      edge_step();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    int nw;
    reset_n = 1'b0;
    wr_full = 1'b0;
    m_burst = 0; m_ptr = 0; m_g = 0; m_cnt = 0;
    clear_q();
    drive();
    @(posedge wr_clk);
    #1;

    // Reset with every requester valid
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k), 1'b0);
    drive();
    sample();
    chk("t1_rst_wen", wr_en, 0);
    chk("t1_rst_ready", req_ready, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_gid", grant_id, 0);
    edge_step();
    reset_n = 1'b1;
    sample();
    chk("t1_idle_busy", busy, 0);
    edge_step();
    sample();
    chk("t1_first_gid", grant_id, 0);
    chk("t1_first_wen", wr_en, 1);
    chk("t1_first_data", data_in, 8'h00);
    edge_step();

    // Requester 2 alone: 0A, 0B, 0C(last)
    do_reset();
    push(2, 8'h0A, 0); push(2, 8'h0B, 0); push(2, 8'h0C, 1);
    drive();
    sample();
    chk("t2_idle_wen", wr_en, 0);
    edge_step();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t2_wen", wr_en, 1);
      chk("t2_data", data_in, 8'h0A + 8'(k));
      chk("t2_gid", grant_id, 2);
      edge_step();
    end
    sample();
    chk("t2_after_busy", busy, 0);
    edge_step();
    push(0, 8'h01, 1); push(1, 8'h11, 1); push(3, 8'h31, 1);
    drive();
    sample();
    edge_step();
    sample();
    chk("t2_next_gid", grant_id, 3);
    chk("t2_next_data", data_in, 8'h31);
    edge_step();

    // All requesters continuously valid: 16 writes in 20 cycles
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 30; k++) push(i, 8'(i * 32 + k), 1'b0);
    drive();
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (wr_en === 1'b1) begin
        chk("t3_grant_seq", grant_id, nw / 4);
        nw++;
      end
      edge_step();
    end
    chk("t3_writes_in_20", nw, 16);
    sample();
    chk("t3_bubble_busy", busy, 0);
    edge_step();
    sample();
    chk("t3_wrap_gid", grant_id, 0);
    chk("t3_wrap_data", data_in, 8'h04);
    edge_step();

    // wr_full stall during word 2 of requester 1
    do_reset();
    push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 0); push(1, 8'h14, 1);
    drive();
    sample(); edge_step();
    sample();
    chk("t4_w1_data", data_in, 8'h11);
    edge_step();
    wr_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("t4_stall_wen", wr_en, 0);
      chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_busy", busy, 1);
      chk("t4_stall_gid", grant_id, 1);
      edge_step();
    end
    wr_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t4_resume_wen", wr_en, 1);
      chk("t4_resume_data", data_in, 8'h12 + 8'(k));
      edge_step();
    end
    sample();
    chk("t4_end_busy", busy, 0);
    edge_step();

    // Requester 3 drops valid after one word
    do_reset();
    push(2, 8'h21, 1); push(3, 8'h31, 0);
    drive();
    sample(); edge_step();
    sample();
    chk("t5_r2_gid", grant_id, 2);
    edge_step();
    sample(); edge_step();
    push(0, 8'h01, 0); push(0, 8'h02, 1); push(1, 8'h41, 1);
    drive();
    sample();
    chk("t5_r3_gid", grant_id, 3);
    chk("t5_r3_data", data_in, 8'h31);
    edge_step();
    sample();
    chk("t5_drop_wen", wr_en, 0);
    chk("t5_drop_busy", busy, 1);
    edge_step();
    sample();
    chk("t5_bubble_busy", busy, 0);
    edge_step();
    sample();
    chk("t5_next_gid", grant_id, 0);
    chk("t5_next_data", data_in, 8'h01);
    edge_step();

    // Reset mid-burst of requester 2
    do_reset();
    for (int k = 0; k < 5; k++) push(2, 8'h50 + 8'(k), 1'b0);
    drive();
    sample(); edge_step();
    sample();
    chk("t6_pre_data", data_in, 8'h50);
    edge_step();
    reset_n = 1'b0;
    #1;
    chk("t6_async_wen", wr_en, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", req_ready, 0);
    chk("t6_async_gid", grant_id, 0);
    sample();
    edge_step();
    reset_n = 1'b1;
    push(0, 8'h01, 1);
    drive();
    sample(); edge_step();
    sample();
    chk("t6_restart_gid", grant_id, 0);
    chk("t6_restart_data", data_in, 8'h01);
    edge_step();

    // Randomized traffic with random back-pressure and occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
      wr_full = ($urandom_range(0, 99) < 25);
      for (int i = 0; i < N; i++) begin
        if ((tl[i] - hd[i]) < 3 && $urandom_range(0, 3) == 0)
          push(i, 8'($urandom), ($urandom_range(0, 2) == 0));
      end
      drive();
      sample();
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ producers in the wr_clk domain. It grants one requester at a time for a bounded burst and forwards that requester's data to the FIFO. It gates the FIFO write-enable with wr_full so the FIFO never overflows. It sits directly in front of the FIFO write side; the read side is unaffected.

Parameters:
WIDTH, 8, data word width; matches FIFO WIDTH
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, grant index width; equals clog2(NUM_REQ)
MAX_BURST, 4, maximum words per grant (1..15)

Ports:
wr_clk  in  1  write-domain clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*WIDTH  packed words; requester i at bits [i*WIDTH +: WIDTH]
req_last  in  NUM_REQ  final word of requester's packet
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
wr_full  in  1  FIFO full flag, wr_clk domain
wr_en  out  1  FIFO write strobe
data_in  out  WIDTH  word to FIFO
grant_id  out  IDX_W  index of current grantee
busy  out  1  high while a grant is held

Behaviour:
- Reset (reset_n low, asynchronous) sets state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0. Outputs go low: busy=0, wr_en=0, req_ready=0. data_in=0.
- FSM has two states, IDLE and BURST.
- IDLE: if any req_valid is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register that index into grant_id, clear burst_cnt and go to BURST. No data moves in IDLE. If no req_valid is set, stay in IDLE.
- BURST: busy=1. req_ready[grant_id] = ~wr_full; all other req_ready bits are 0.
- Transfer condition: req_valid[grant_id] & ~wr_full. On a transfer, wr_en=1 combinationally, data_in = req_data slice for grant_id, and burst_cnt increments. There is zero-cycle latency from requester to FIFO.
- wr_en is never 1 while wr_full=1. When wr_full is high the burst stalls: it holds the grant and burst_cnt does not advance.
- A burst ends on the cycle of a transfer that either carries req_last[grant_id]=1 or makes burst_cnt reach MAX_BURST.
- A burst also ends when req_valid[grant_id]=0 in BURST, whether or not wr_full is high.
- On burst end: rr_ptr <= grant_id+1 (wraps modulo NUM_REQ; NUM_REQ not a power of two wraps at NUM_REQ-1 -> 0), state <= IDLE. This gives one idle bubble cycle between grants.
- Requesters keep req_valid, req_data and req_last stable while req_ready=0.
- A packet longer than MAX_BURST is split: the remainder is re-arbitrated later. req_last is only meaningful on the word where it is asserted.
- data_in is muxed whenever state=BURST. FIFO samples it only when wr_en=1.
- Reset asserted mid-burst aborts immediately. A word presented in that cycle is not written, and rr_ptr returns to 0.
- Width rules: burst_cnt is 4 bits and cannot overflow because MAX_BURST<=15. grant_id and rr_ptr are IDX_W bits.

Decomposition:
- Package fifo_arb_pkg holds the state enum (IDLE, BURST) and the MAX_BURST and counter-width localparams, shared with the bench.
- One sub-module, rr_pick: combinational round-robin first-set-bit finder. Inputs are req vector and rr_ptr; outputs are found flag and index.

Test Plan:
- Reset with reset_n=0 and all req_valid=1 -> wr_en=0, req_ready=0, busy=0, grant_id=0. Release reset -> grant to requester 0 after one IDLE cycle.
- Requester 2 alone sends 0x0A,0x0B,0x0C with last on 0x0C, wr_full=0 -> three consecutive wr_en cycles with data_in=0A,0B,0C and grant_id=2. Then IDLE; next scan starts at requester 3.
- All four requesters continuously valid, no last, MAX_BURST=4 -> grants 0,1,2,3,0 with exactly 4 writes each. One bubble between grants; 16 writes in 20 cycles.
- wr_full high for 3 cycles during word 2 of requester 1's burst -> wr_en=0 and req_ready[1]=0 for those cycles with grant held. Word 2 is written on the first cycle wr_full=0; no word is lost or duplicated.
- Requester 3 drops req_valid after 1 word -> burst ends, rr_ptr=0, requester 0 is served next.
- reset_n pulsed low mid-burst of requester 2 -> outputs go low asynchronously in the same cycle. After release, arbitration restarts from requester 0.
